// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Queues ALU commands, issues them one at a time, and returns
//               results (or timeout markers) in command order.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_opcode,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic       alu_start,
   output logic [1:0] alu_opcode,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result,
   input  logic       alu_done,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [1:0] res_opcode,
   output logic       res_timeout,
   output logic       busy
);

   localparam int              C_PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              C_CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [C_CW-1:0] C_FULL     = C_CW'(FIFO_DEPTH);
   localparam logic [7:0]      C_TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   logic [17:0]     fifo_mem_q [FIFO_DEPTH];
   logic [C_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [C_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [C_CW-1:0] count_q, count_d;
   state_t          state_q, state_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
   logic [1:0]      alu_opcode_q, alu_opcode_d;
   logic [7:0]      alu_a_q, alu_a_d;
   logic [7:0]      alu_b_q, alu_b_d;
   logic            res_valid_q, res_valid_d;
   logic [7:0]      res_data_q, res_data_d;
   logic [1:0]      res_opcode_q, res_opcode_d;
   logic            res_timeout_q, res_timeout_d;
   logic            do_push;
   logic            do_pop;

   // No pass-through: a full queue refuses even when a pop happens this cycle.
   assign cmd_ready = (count_q != C_FULL) && !reset;
   assign do_push   = cmd_valid && cmd_ready;
   assign do_pop    = (state_q == IDLE) && (count_q != '0);

   assign alu_opcode  = alu_opcode_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_opcode  = res_opcode_q;
   assign res_timeout = res_timeout_q;
   assign busy        = (state_q != IDLE) || (count_q != '0);

   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_mem_q[wr_ptr_q] <= {cmd_opcode, cmd_a, cmd_b};
      end
   end

   always_comb begin
      wr_ptr_d      = do_push ? wr_ptr_q + C_PW'(1) : wr_ptr_q;
      rd_ptr_d      = do_pop  ? rd_ptr_q + C_PW'(1) : rd_ptr_q;
      count_d       = count_q;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      alu_opcode_d  = alu_opcode_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_opcode_d  = res_opcode_q;
      res_timeout_d = res_timeout_q;
      alu_start     = 1'b0;

      if (do_push && !do_pop) begin
         count_d = count_q + C_CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - C_CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (do_pop) begin
               {alu_opcode_d, alu_a_d, alu_b_d} = fifo_mem_q[rd_ptr_q];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            alu_start  = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = WAIT;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            // A done still high from the previous operation is ignored on the first WAIT edge.
            if (alu_done && (wait_cnt_q != 8'd0)) begin
               res_data_d    = alu_result;
               res_opcode_d  = alu_opcode_q;
               res_timeout_d = 1'b0;
               res_valid_d   = 1'b1;
               state_d       = HOLD;
            end else if (wait_cnt_q == C_TMO_LAST) begin
               res_data_d    = 8'hFF;
               res_opcode_d  = alu_opcode_q;
               res_timeout_d = 1'b1;
               res_valid_d   = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         state_q       <= IDLE;
         wait_cnt_q    <= 8'd0;
         alu_opcode_q  <= 2'd0;
         alu_a_q       <= 8'd0;
         alu_b_q       <= 8'd0;
         res_valid_q   <= 1'b0;
         res_data_q    <= 8'd0;
         res_opcode_q  <= 2'd0;
         res_timeout_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         alu_opcode_q  <= alu_opcode_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_opcode_q  <= res_opcode_d;
         res_timeout_q <= res_timeout_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command queue entries (power of two, 2..16).
REQ-002 Parameter: TIMEOUT, 64, maximum WAIT cycles before abandoning an operation (2..255).
REQ-003 One clock; reset is synchronous and active-high: ports clk, reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  queue can accept a command.
REQ-008 cmd_opcode  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-009 cmd_a  input  8  operand A.
REQ-010 cmd_b  input  8  operand B.
REQ-011 alu_start  output  1  one-cycle start pulse to the ALU.
REQ-012 alu_opcode  output  2  opcode held to the ALU.
REQ-013 alu_a  output  8  operand A held to the ALU.
REQ-014 alu_b  output  8  operand B held to the ALU.
REQ-015 alu_result  input  8  ALU outbus.
REQ-016 alu_done  input  1  ALU completion flag (level).
REQ-017 res_valid  output  1  result available.
REQ-018 res_ready  input  1  consumer accepts the result.
REQ-019 res_data  output  8  captured result.
REQ-020 res_opcode  output  2  opcode that produced res_data.
REQ-021 res_timeout  output  1  result is a timeout marker.
REQ-022 busy  output  1  queue non-empty or FSM not IDLE.

Function
REQ-023 FIFO: FIFO_DEPTH entries of {opcode, a, b}; push on cmd_valid && cmd_ready; cmd_ready = !full && !reset (combinational from occupancy count).
REQ-024 Push and pop in the same cycle are legal when non-empty; occupancy is unchanged; on full, cmd_ready=0 even if a pop occurs that cycle (no pass-through).
REQ-025 Pointers wrap modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH.
REQ-026 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-027 IDLE: if FIFO non-empty at an edge -> pop, load alu_opcode/alu_a/alu_b, go to ISSUE; else stay.
REQ-028 ISSUE: alu_start=1 for exactly this cycle; next edge -> WAIT with wait counter=0.
REQ-029 alu_opcode/alu_a/alu_b stay stable from the ISSUE load until HOLD exits.
REQ-030 WAIT: alu_done is ignored on the first WAIT edge (stale-done guard) and sampled on every later edge; the counter increments each WAIT edge.
REQ-031 WAIT, alu_done=1 (sampled): res_data<=alu_result, res_opcode<=alu_opcode, res_timeout<=0, res_valid<=1, go to HOLD.
REQ-032 WAIT, counter reaches TIMEOUT-1 with no sampled done: res_data<=8'hFF, res_timeout<=1, res_valid<=1, go to HOLD; done and timeout on the same edge -> done wins.
REQ-033 HOLD: res_* held stable while res_ready=0; on res_valid && res_ready edge -> res_valid<=0, go to IDLE.
REQ-034 Minimum latency, with the ALU asserting done 1 cycle after start: push at edge k, alu_start high in cycle k+1..k+2, result valid after edge k+4.
REQ-035 Exactly one ALU operation is in flight; results return in command order.
REQ-036 busy = (state != IDLE) || (occupancy != 0).

Reset
REQ-037 While reset=1 at an edge: FIFO emptied, pointers/count=0, state=IDLE, counter=0.
REQ-038 Reset values: alu_start=0, alu_opcode=0, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_opcode=0, res_timeout=0, busy=0; cmd_ready=0 during reset, 1 the cycle after.
REQ-039 Reset mid-operation (any state) discards the queued and in-flight commands; no result is produced for them.

Verification
REQ-040 add 25+17, ALU model done 1 cycle after start, res_ready=1 -> res_data=42, res_opcode=00, res_timeout=0, res_valid for 1 cycle.
REQ-041 5 back-to-back commands with the FSM stalled in HOLD (res_ready=0) -> 4 accepted, cmd_ready=0 on the 5th; after release, results come back in order.
REQ-042 alu_done never asserted, TIMEOUT=64 -> res_data=FF and res_timeout=1 exactly 64 WAIT cycles after ISSUE; next command then issues normally.
REQ-043 alu_done held high from the previous op into the new WAIT -> first WAIT edge ignored; result captured on the second WAIT edge.
REQ-044 res_ready=0 for 10 cycles -> res_data/res_opcode stable, no alu_start pulse, queued commands retained.
REQ-045 reset pulsed during WAIT with 2 queued commands -> all outputs at reset values next cycle, busy=0, no stale result after reset deassertion.
